// File: rtl/register_dump_unit.sv
// Walks an index range of an attached register file and streams each register
// out as a valid/ready beat, flagging the final beat and pulsing done at the end.
module register_dump_unit #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned IDX_W = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  first,
  input  logic [IDX_W-1:0]  last,
  output logic [IDX_W-1:0]  rd_index,
  input  logic [31:0]       rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StSend,
    StDone
  } state_e;

  localparam int unsigned     MaxIdxInt = SIZE - 1;
  localparam logic [IDX_W:0]  MaxIdx    = MaxIdxInt[IDX_W:0];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic [IDX_W-1:0] end_q, end_d;
  word_t            out_data_q, out_data_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;

  logic [IDX_W:0]   first_ext;
  logic [IDX_W:0]   last_ext;
  logic [IDX_W:0]   end_clip_ext;
  logic             last_beat;

  // One extra bit so out-of-range indices compare correctly for non-power-of-two SIZE.
  assign first_ext    = {1'b0, first};
  assign last_ext     = {1'b0, last};
  assign end_clip_ext = (last_ext > MaxIdx) ? MaxIdx : last_ext;
  assign last_beat    = (out_index_q == end_q);

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_d       = end_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          cur_d = first;
          end_d = end_clip_ext[IDX_W-1:0];
          // end is already clipped to SIZE-1, so this also rejects first >= SIZE.
          if (first_ext > end_clip_ext) begin
            state_d = StDone;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          out_data_d  = rd_data;
          out_index_d = cur_q;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (abort) begin
          state_d = StIdle;
        end else if (out_ready) begin
          if (last_beat) begin
            state_d = StDone;
          end else begin
            cur_d   = cur_q + {{(IDX_W-1){1'b0}}, 1'b1};
            state_d = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      end_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  assign rd_index  = cur_q;
  assign out_valid = (state_q == StSend);
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = (state_q == StSend) && last_beat;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_register_dump_unit.sv
// Directed bench for register_dump_unit: a 32-entry register file holding
// x[i] = i*16 feeds rd_data combinationally from rd_index.
module tb_register_dump_unit;

  localparam int unsigned SIZE  = 32;
  localparam int unsigned IDX_W = 5;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [IDX_W-1:0] first;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] rd_index;
  logic [31:0]      rd_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             busy;
  logic             done;

  logic [31:0] regs [SIZE];
  int          n_assert;
  int          n_fail;
  int          cyc;

  register_dump_unit #(
    .SIZE (SIZE),
    .IDX_W(IDX_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .first    (first),
    .last     (last),
    .rd_index (rd_index),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  assign rd_data = regs[rd_index];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge, then settle 1 time unit before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_index"}, 32'(rd_index), 32'h0);
    check({tag, " out_valid"}, 32'(out_valid), 32'h0);
    check({tag, " out_data"}, out_data, 32'h0);
    check({tag, " out_index"}, 32'(out_index), 32'h0);
    check({tag, " out_last"}, 32'(out_last), 32'h0);
    check({tag, " busy"}, 32'(busy), 32'h0);
    check({tag, " done"}, 32'(done), 32'h0);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    cyc       = 0;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    first     = '0;
    last      = '0;
    out_ready = 1'b1;
    for (int i = 0; i < int'(SIZE); i++) regs[i] = 32'(i * 16);

    #12;
    check_all_zero("reset");
    step();
    reset = 1'b0;

    // Range 0..3 with out_ready tied high: 4 beats, done on the 9th edge.
    first = 5'd0;
    last  = 5'd3;
    start = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      start = 1'b0;
      check("r03 read valid", 32'(out_valid), 32'h0);
      check("r03 read busy", 32'(busy), 32'h1);
      check("r03 rd_index", 32'(rd_index), 32'(i));
      step();
      check("r03 send valid", 32'(out_valid), 32'h1);
      check("r03 out_index", 32'(out_index), 32'(i));
      check("r03 out_data", out_data, 32'(i * 16));
      check("r03 out_last", 32'(out_last), (i == 3) ? 32'h1 : 32'h0);
    end
    step();
    check("r03 done", 32'(done), 32'h1);
    check("r03 done latency", 32'(cyc), 32'd9);
    check("r03 done no valid", 32'(out_valid), 32'h0);
    step();
    check("r03 done pulse", 32'(done), 32'h0);
    check("r03 idle busy", 32'(busy), 32'h0);

    // Single register 5 with the consumer stalling for 4 SEND cycles.
    first = 5'd5;
    last  = 5'd5;
    start = 1'b1;
    step();
    start     = 1'b0;
    out_ready = 1'b0;
    check("r55 rd_index", 32'(rd_index), 32'd5);
    for (int i = 0; i < 4; i++) begin
      step();
      check("r55 stall valid", 32'(out_valid), 32'h1);
      check("r55 stall data", out_data, 32'h50);
      check("r55 stall index", 32'(out_index), 32'd5);
      check("r55 stall last", 32'(out_last), 32'h1);
    end
    out_ready = 1'b1;
    step();
    check("r55 done", 32'(done), 32'h1);
    check("r55 valid off", 32'(out_valid), 32'h0);
    step();
    check("r55 idle", 32'(busy), 32'h0);

    // Empty range 7..2: straight to DONE, busy for one cycle only.
    first = 5'd7;
    last  = 5'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    check("r72 done", 32'(done), 32'h1);
    check("r72 busy", 32'(busy), 32'h1);
    check("r72 no beat", 32'(out_valid), 32'h0);
    step();
    check("r72 busy off", 32'(busy), 32'h0);
    check("r72 done off", 32'(done), 32'h0);

    // Top of the file 30..31 with a stray start in SEND.
    first = 5'd30;
    last  = 5'd31;
    start = 1'b1;
    step();
    start = 1'b0;
    check("r30 rd_index", 32'(rd_index), 32'd30);
    step();
    check("r30 index", 32'(out_index), 32'd30);
    check("r30 data", out_data, 32'h1e0);
    check("r30 last", 32'(out_last), 32'h0);
    first = 5'd0;
    last  = 5'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("r31 rd_index", 32'(rd_index), 32'd31);
    step();
    check("r31 index", 32'(out_index), 32'd31);
    check("r31 data", out_data, 32'h1f0);
    check("r31 last", 32'(out_last), 32'h1);
    step();
    check("r31 done", 32'(done), 32'h1);
    check("r31 cur no wrap", 32'(rd_index), 32'd31);
    step();
    check("r31 idle", 32'(busy), 32'h0);

    // Abort in SEND of the second beat of 0..7, then restart at 4.
    first = 5'd0;
    last  = 5'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("abort pre valid", 32'(out_valid), 32'h1);
    check("abort pre index", 32'(out_index), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort busy", 32'(busy), 32'h0);
    check("abort valid", 32'(out_valid), 32'h0);
    check("abort done", 32'(done), 32'h0);
    step();
    check("abort no done", 32'(done), 32'h0);
    check("abort stays idle", 32'(busy), 32'h0);
    first = 5'd4;
    last  = 5'd4;
    start = 1'b1;
    abort = 1'b1;
    step();
    check("start+abort idle", 32'(busy), 32'h0);
    abort = 1'b0;
    step();
    start = 1'b0;
    check("restart rd_index", 32'(rd_index), 32'd4);
    step();
    check("restart index", 32'(out_index), 32'd4);
    check("restart data", out_data, 32'h40);
    check("restart last", 32'(out_last), 32'h1);
    step();
    check("restart done", 32'(done), 32'h1);
    step();

    // Asynchronous reset between edges while in READ.
    first = 5'd2;
    last  = 5'd6;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("pre-reset rd_index", 32'(rd_index), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async reset");
    #2;
    reset = 1'b0;
    first = 5'd3;
    last  = 5'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    check("post-reset busy", 32'(busy), 32'h1);
    check("post-reset rd_index", 32'(rd_index), 32'd3);
    step();
    check("post-reset data", out_data, 32'h30);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/register_dump_unit.md
REGISTER_DUMP_UNIT -- requirements
Module: register_dump_unit

Interface
REQ-001 SHALL have parameter SIZE, default 32, meaning the number of registers in the attached register file.
REQ-002 SHALL have derived parameter IDX_W, default $clog2(SIZE), meaning the width of the register index.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  meaning the dump request, sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  meaning cancel of the current dump.
REQ-007 SHALL have port first  input  IDX_W  meaning the first register index, sampled with start.
REQ-008 SHALL have port last  input  IDX_W  meaning the last register index, sampled with start.
REQ-009 SHALL have port rd_index  output  IDX_W  meaning the read address driven to the register unit's read port.
REQ-010 SHALL have port rd_data  input  32 (word_t)  meaning combinational read data for rd_index, valid in the same cycle.
REQ-011 SHALL have port out_valid  output  1  meaning a dump beat is presented.
REQ-012 SHALL have port out_ready  input  1  meaning the consumer accepts the beat.
REQ-013 SHALL have port out_data  output  32 (word_t)  meaning the register value of the beat.
REQ-014 SHALL have port out_index  output  IDX_W  meaning the register index of the beat.
REQ-015 SHALL have port out_last  output  1  meaning the beat is the final one of the dump.
REQ-016 SHALL have port busy  output  1  meaning the unit is in any state other than IDLE.
REQ-017 SHALL have port done  output  1  meaning a one-cycle pulse on normal completion.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, SEND and DONE.
REQ-019 IDLE with start=1 SHALL latch first as cur and min(last,SIZE-1) as end, and SHALL go to READ.
REQ-020 In IDLE with start=1, if first>end or first>=SIZE, the FSM SHALL go to DONE instead and emit no beat.
REQ-021 READ SHALL drive rd_index=cur, capture rd_data into out_data and cur into out_index at the edge, and go to SEND; READ lasts exactly one cycle.
REQ-022 SEND SHALL hold out_valid=1 with stable out_data, out_index and out_last until out_valid and out_ready are both 1.
REQ-023 out_last SHALL be 1 in SEND exactly when out_index equals end.
REQ-024 On a SEND handshake with out_last=0, the FSM SHALL increment cur by 1 and go to READ; on a handshake with out_last=1, it SHALL go to DONE.
REQ-025 DONE SHALL assert done=1 for one cycle and go to IDLE.
REQ-026 Each beat SHALL occupy at least 2 cycles (READ plus SEND); N registers with out_ready tied to 1 SHALL give done exactly 2N+1 cycles after the start edge.
REQ-027 rd_index SHALL equal cur in every state; outside READ its value is don't-care to consumers.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 abort=1 in READ, SEND or DONE SHALL force IDLE at the next edge, with out_valid=0 and done=0 from then on; abort SHALL take precedence over a simultaneous handshake.
REQ-030 abort=1 together with start=1 in IDLE SHALL leave the FSM in IDLE.
REQ-031 cur SHALL never wrap: with end<=SIZE-1, it never increments past end.
REQ-032 out_valid SHALL be 1 only in SEND; busy SHALL be 1 in READ, SEND and DONE.

Reset
REQ-033 Asserting reset SHALL immediately force state=IDLE, cur=0, end=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0 and rd_index=0, including when asserted mid-dump.
REQ-034 After reset is released, the first start SHALL be accepted on the next rising edge.

Verification
REQ-035 SIZE=32, first=0, last=3, out_ready=1, registers preloaded x[i]=i*16 -> beats (0,0x00),(1,0x10),(2,0x20),(3,0x30), out_last on index 3, done 9 cycles after start.
REQ-036 first=5, last=5, out_ready low for 4 cycles in SEND -> out_valid held with out_data=x[5] stable, one beat with out_last=1, then done.
REQ-037 first=7, last=2 -> no beat, done 1 cycle after start, busy high for exactly 1 cycle.
REQ-038 first=30, last=31 (SIZE=32), with a start pulse in SEND -> beats 30 and 31 only, second start ignored, cur never exceeds 31.
REQ-039 abort asserted in SEND of the second beat of 0..7 -> IDLE next cycle, out_valid=0, no done pulse; a new start afterwards restarts from the new first.
REQ-040 reset asserted asynchronously between edges during READ -> all outputs 0 immediately, FSM in IDLE.
